// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, data, loader and RAM-side signals of the
// shared-RAM arbiter.
//   slave  : the arbiter's view. Requests and ram_rdata come in; grants,
//            read responses and the RAM strobe go out.
//   master : the environment's view (core, loader and RAM), the reverse.
// With ARB_PERF_CNT_EN defined the interface also carries the arbiter's
// performance counters cnt_if, cnt_d, cnt_ld and cnt_stall.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int unsigned AW = 12
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;

  logic          ld_lock;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          locked;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0]   cnt_if;
  logic [31:0]   cnt_d;
  logic [31:0]   cnt_ld;
  logic [31:0]   cnt_stall;
`endif

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  ld_lock, ld_req, ld_addr, ld_wdata,
    output ld_gnt, locked,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
`ifdef ARB_PERF_CNT_EN
    , output cnt_if, cnt_d, cnt_ld, cnt_stall
`endif
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output ld_lock, ld_req, ld_addr, ld_wdata,
    input  ld_gnt, locked,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
`ifdef ARB_PERF_CNT_EN
    , input cnt_if, cnt_d, cnt_ld, cnt_stall
`endif
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between core fetch (if), core data
// (d) and the UART program loader (ld). One access per cycle, grants are
// combinational in the request cycle, read data returns to its owner one
// cycle later. ld_lock parks the core off the memory while an image loads.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - mem_arbiter_if.slave (requesters, loader lock, RAM side)
// Optional: define ARB_PERF_CNT_EN to add grant/stall counters on bus.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOCK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0]   if_hold_q, d_hold_q;

  logic          core_ok, promote, locked_c;
  logic          gnt_if, gnt_d, gnt_ld;
  logic          ram_en_c;
  logic [3:0]    ram_we_c;
  logic [AW-1:0] ram_addr_c;
  logic [31:0]   ram_wdata_c;

  assign promote = (wait_q >= WW'(MAX_WAIT));

  // Next state, grant selection, starvation counter and RAM mux
  always_comb begin
    state_d     = state_q;
    owner_d     = OWN_NONE;
    wait_d      = '0;
    core_ok     = 1'b0;
    locked_c    = 1'b0;
    gnt_if      = 1'b0;
    gnt_d       = 1'b0;
    gnt_ld      = 1'b0;
    ram_en_c    = 1'b0;
    ram_we_c    = 4'b0000;
    ram_addr_c  = '0;
    ram_wdata_c = 32'h0;

    case (state_q)
      S_RUN: begin
        // Core is held off from the very cycle the lock is seen
        core_ok = !bus.ld_lock;
        if (bus.ld_lock) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_LOCK;
      S_LOCK: begin
        locked_c = bus.ld_lock;
        if (!bus.ld_lock) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    // rst gates every grant so nothing reaches the RAM while in reset
    if (rst) begin
      if (bus.ld_req) begin
        gnt_ld = 1'b1;
      end else if (core_ok) begin
        if (promote) begin
          if (bus.if_req)     gnt_if = 1'b1;
          else if (bus.d_req) gnt_d  = 1'b1;
        end else begin
          if (bus.d_req)       gnt_d  = 1'b1;
          else if (bus.if_req) gnt_if = 1'b1;
        end
      end
    end

    // Starvation count only runs in S_RUN, so leaving the lock starts at 0
    if (state_q == S_RUN && bus.if_req && !gnt_if)
      wait_d = promote ? wait_q : wait_q + WW'(1);

    if (gnt_ld) begin
      ram_en_c    = 1'b1;
      ram_we_c    = 4'b1111;
      ram_addr_c  = bus.ld_addr;
      ram_wdata_c = bus.ld_wdata;
    end else if (gnt_d) begin
      ram_en_c    = 1'b1;
      ram_we_c    = bus.d_we ? bus.d_be : 4'b0000;
      ram_addr_c  = bus.d_addr;
      ram_wdata_c = bus.d_wdata;
    end else if (gnt_if) begin
      ram_en_c    = 1'b1;
      ram_addr_c  = bus.if_addr;
    end

    // A d write with d_be = 0 is a no-op write, not a read, so it gets no owner
    if (gnt_if)                  owner_d = OWN_IF;
    else if (gnt_d && !bus.d_we) owner_d = OWN_D;
  end

  // State, owner and read-data hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      owner_q   <= OWN_NONE;
      wait_q    <= '0;
      if_hold_q <= 32'h0;
      d_hold_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wait_q  <= wait_d;
      if (owner_q == OWN_IF) if_hold_q <= bus.ram_rdata;
      if (owner_q == OWN_D)  d_hold_q  <= bus.ram_rdata;
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.ld_gnt    = gnt_ld;
  assign bus.locked    = locked_c;
  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;

  // Response cycle passes RAM data straight through; otherwise last value holds
  assign bus.if_rvalid = (owner_q == OWN_IF);
  assign bus.d_rvalid  = (owner_q == OWN_D);
  assign bus.if_rdata  = (owner_q == OWN_IF) ? bus.ram_rdata : if_hold_q;
  assign bus.d_rdata   = (owner_q == OWN_D)  ? bus.ram_rdata : d_hold_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] cnt_if_q, cnt_d_q, cnt_ld_q, cnt_stall_q;

  // Grant and core-stall counters; free-running, wrap, survive the lock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_if_q    <= 32'h0;
      cnt_d_q     <= 32'h0;
      cnt_ld_q    <= 32'h0;
      cnt_stall_q <= 32'h0;
    end else begin
      if (gnt_if) cnt_if_q <= cnt_if_q + 32'd1;
      if (gnt_d)  cnt_d_q  <= cnt_d_q + 32'd1;
      if (gnt_ld) cnt_ld_q <= cnt_ld_q + 32'd1;
      if ((bus.if_req || bus.d_req) && !(gnt_if || gnt_d))
        cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  assign bus.cnt_if    = cnt_if_q;
  assign bus.cnt_d     = cnt_d_q;
  assign bus.cnt_ld    = cnt_ld_q;
  assign bus.cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural 4096-word RAM.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;
  logic [31:0] mem [0:4095];

  mem_arbiter_if #(.AW(12)) bus ();

  mem_arbiter #(.AW(12), .MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM: byte-enabled writes, 1-cycle read latency
  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      if (bus.ram_we == 4'b0000) bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 12'h020; bus.d_wdata = 32'h0;
    bus.ld_lock = 1'b0; bus.ld_req = 1'b1; bus.ld_addr = 12'h0; bus.ld_wdata = 32'h0;
    #3;
    total_cnt++; if (bus.if_gnt !== 1'b0) $display("FAIL rst_if_gnt: got %b exp 0", bus.if_gnt); else pass_cnt++;
    total_cnt++; if (bus.d_gnt !== 1'b0) $display("FAIL rst_d_gnt: got %b exp 0", bus.d_gnt); else pass_cnt++;
    total_cnt++; if (bus.ld_gnt !== 1'b0) $display("FAIL rst_ld_gnt: got %b exp 0", bus.ld_gnt); else pass_cnt++;
    total_cnt++; if (bus.ram_en !== 1'b0) $display("FAIL rst_ram_en: got %b exp 0", bus.ram_en); else pass_cnt++;
    total_cnt++; if (bus.ram_we !== 4'h0) $display("FAIL rst_ram_we: got %h exp 0", bus.ram_we); else pass_cnt++;
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL rst_locked: got %b exp 0", bus.locked); else pass_cnt++;
    total_cnt++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b%b exp 00", bus.if_rvalid, bus.d_rvalid); else pass_cnt++;
    total_cnt++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) $display("FAIL rst_rdata: got %h %h exp 0 0", bus.if_rdata, bus.d_rdata); else pass_cnt++;
`ifdef ARB_PERF_CNT_EN
    total_cnt++; if ((bus.cnt_if | bus.cnt_d | bus.cnt_ld | bus.cnt_stall) !== 32'h0) $display("FAIL rst_cnt: got %h %h %h %h exp 0", bus.cnt_if, bus.cnt_d, bus.cnt_ld, bus.cnt_stall); else pass_cnt++;
`endif
    repeat (2) @(negedge clk);
    bus.if_req = 1'b0; bus.d_req = 1'b0; bus.ld_req = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    total_cnt++; if (bus.ram_en !== 1'b0 || bus.locked !== 1'b0) $display("FAIL post_rst_idle: got en=%b locked=%b exp 0 0", bus.ram_en, bus.locked); else pass_cnt++;
  endtask

  // Loader writes while unlocked also go straight to the RAM at top priority
  task automatic test_ld_unlocked();
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 12'h010; bus.ld_wdata = 32'h0000_0013;
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    #1;
    total_cnt++; if (bus.ld_gnt !== 1'b1 || bus.if_gnt !== 1'b0) $display("FAIL ld_prio: got ld=%b if=%b exp 1 0", bus.ld_gnt, bus.if_gnt); else pass_cnt++;
    total_cnt++; if (bus.ram_we !== 4'hF || bus.ram_addr !== 12'h010) $display("FAIL ld_ram: got we=%h addr=%h exp f 010", bus.ram_we, bus.ram_addr); else pass_cnt++;
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.ld_addr = 12'h020; bus.ld_wdata = 32'h1122_3344;
    #1;
    total_cnt++; if (bus.ld_gnt !== 1'b1 || bus.ram_wdata !== 32'h1122_3344) $display("FAIL ld_write2: got gnt=%b wdata=%h exp 1 11223344", bus.ld_gnt, bus.ram_wdata); else pass_cnt++;
    @(negedge clk);
    bus.ld_req = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    #1;
    total_cnt++; if (bus.if_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b exp 1", bus.if_gnt); else pass_cnt++;
    total_cnt++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 4'h0 || bus.ram_addr !== 12'h010) $display("FAIL fetch_ram: got en=%b we=%h addr=%h exp 1 0 010", bus.ram_en, bus.ram_we, bus.ram_addr); else pass_cnt++;
    @(negedge clk);
    bus.if_req = 1'b0;
    #1;
    total_cnt++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0013) $display("FAIL fetch_resp: got v=%b data=%h exp 1 00000013", bus.if_rvalid, bus.if_rdata); else pass_cnt++;
    total_cnt++; if (bus.d_rvalid !== 1'b0) $display("FAIL fetch_d_rvalid: got %b exp 0", bus.d_rvalid); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0000_0013) $display("FAIL fetch_hold: got v=%b data=%h exp 0 00000013", bus.if_rvalid, bus.if_rdata); else pass_cnt++;
  endtask

  task automatic test_partial_write();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 12'h020; bus.d_wdata = 32'hAABB_CCDD;
    #1;
    total_cnt++; if (bus.d_gnt !== 1'b1 || bus.ram_we !== 4'b0011) $display("FAIL pw_gnt: got gnt=%b we=%h exp 1 3", bus.d_gnt, bus.ram_we); else pass_cnt++;
    @(negedge clk);
    bus.d_be = 4'b0000; bus.d_wdata = 32'hFFFF_FFFF;
    #1;
    total_cnt++; if (bus.d_rvalid !== 1'b0) $display("FAIL pw_no_rvalid: got %b exp 0", bus.d_rvalid); else pass_cnt++;
    total_cnt++; if (bus.d_gnt !== 1'b1 || bus.ram_we !== 4'b0000) $display("FAIL noop_gnt: got gnt=%b we=%h exp 1 0", bus.d_gnt, bus.ram_we); else pass_cnt++;
    @(negedge clk);
    bus.d_we = 1'b0;
    #1;
    total_cnt++; if (bus.d_rvalid !== 1'b0) $display("FAIL noop_no_rvalid: got %b exp 0", bus.d_rvalid); else pass_cnt++;
    @(negedge clk);
    bus.d_req = 1'b0;
    #1;
    total_cnt++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1122_CCDD) $display("FAIL pw_readback: got v=%b data=%h exp 1 1122ccdd", bus.d_rvalid, bus.d_rdata); else pass_cnt++;
  endtask

  // if and d contend; fetch must win once after 8 consecutive denials
  task automatic test_starvation();
    logic exp_if;
    logic prev_if;
    prev_if = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 12'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    for (int i = 0; i < 20; i++) begin
      #1;
      exp_if = ((i % 9) == 8);
      total_cnt++; if (bus.if_gnt !== exp_if || bus.d_gnt !== !exp_if) $display("FAIL starve_gnt[%0d]: got if=%b d=%b exp if=%b", i, bus.if_gnt, bus.d_gnt, exp_if); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (bus.if_rvalid !== prev_if || bus.d_rvalid !== !prev_if) $display("FAIL starve_rv[%0d]: got if=%b d=%b exp if=%b", i, bus.if_rvalid, bus.d_rvalid, prev_if); else pass_cnt++;
        total_cnt++; if ((prev_if ? bus.if_rdata : bus.d_rdata) !== (prev_if ? 32'h0000_0013 : 32'h1122_CCDD)) $display("FAIL starve_data[%0d]: got if=%h d=%h", i, bus.if_rdata, bus.d_rdata); else pass_cnt++;
      end
      prev_if = exp_if;
      @(negedge clk);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    #1;
    total_cnt++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1122_CCDD) $display("FAIL starve_last: got v=%b data=%h exp 1 1122ccdd", bus.d_rvalid, bus.d_rdata); else pass_cnt++;
  endtask

  task automatic test_lock();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    #1;
    total_cnt++; if (bus.d_gnt !== 1'b1) $display("FAIL lock_pre_gnt: got %b exp 1", bus.d_gnt); else pass_cnt++;
    @(negedge clk);
    bus.ld_lock = 1'b1; bus.if_req = 1'b1; bus.if_addr = 12'h010;
    #1;
    total_cnt++; if (bus.d_gnt !== 1'b0 || bus.if_gnt !== 1'b0) $display("FAIL lock_seen_gnt: got d=%b if=%b exp 0 0", bus.d_gnt, bus.if_gnt); else pass_cnt++;
    total_cnt++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h1122_CCDD) $display("FAIL lock_pending_rd: got v=%b data=%h exp 1 1122ccdd", bus.d_rvalid, bus.d_rdata); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.locked !== 1'b0 || bus.d_gnt !== 1'b0 || bus.d_rvalid !== 1'b0) $display("FAIL drain: got locked=%b gnt=%b rv=%b exp 0 0 0", bus.locked, bus.d_gnt, bus.d_rvalid); else pass_cnt++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      total_cnt++; if (bus.locked !== 1'b1 || bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) $display("FAIL locked[%0d]: got locked=%b if=%b d=%b exp 1 0 0", i, bus.locked, bus.if_gnt, bus.d_gnt); else pass_cnt++;
    end
    @(negedge clk);
    bus.ld_req = 1'b1; bus.ld_addr = 12'h000; bus.ld_wdata = 32'hDEAD_BEEF;
    #1;
    total_cnt++; if (bus.ld_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) $display("FAIL lock_ld_gnt: got ld=%b if=%b d=%b exp 1 0 0", bus.ld_gnt, bus.if_gnt, bus.d_gnt); else pass_cnt++;
    total_cnt++; if (bus.ram_we !== 4'hF || bus.ram_addr !== 12'h000 || bus.ram_wdata !== 32'hDEAD_BEEF) $display("FAIL lock_ld_ram: got we=%h addr=%h wd=%h", bus.ram_we, bus.ram_addr, bus.ram_wdata); else pass_cnt++;
    @(negedge clk);
    bus.ld_req = 1'b0; bus.ld_lock = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
    #1;
    total_cnt++; if (bus.locked !== 1'b0) $display("FAIL unlock_locked: got %b exp 0", bus.locked); else pass_cnt++;
`ifdef ARB_PERF_CNT_EN
    total_cnt++; if (bus.cnt_ld !== 32'd3) $display("FAIL cnt_ld: got %0d exp 3", bus.cnt_ld); else pass_cnt++;
`endif
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 12'h000;
    #1;
    total_cnt++; if (bus.if_gnt !== 1'b1) $display("FAIL unlock_if_gnt: got %b exp 1", bus.if_gnt); else pass_cnt++;
    @(negedge clk);
    bus.if_req = 1'b0;
    #1;
    total_cnt++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hDEAD_BEEF) $display("FAIL unlock_fetch: got v=%b data=%h exp 1 deadbeef", bus.if_rvalid, bus.if_rdata); else pass_cnt++;
  endtask

  task automatic test_reset_midread();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h020;
    #1;
    total_cnt++; if (bus.d_gnt !== 1'b1) $display("FAIL mid_gnt: got %b exp 1", bus.d_gnt); else pass_cnt++;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) $display("FAIL mid_rvalid: got d=%b if=%b exp 0 0", bus.d_rvalid, bus.if_rvalid); else pass_cnt++;
    total_cnt++; if (bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h0) $display("FAIL mid_rdata: got d=%h if=%h exp 0 0", bus.d_rdata, bus.if_rdata); else pass_cnt++;
`ifdef ARB_PERF_CNT_EN
    total_cnt++; if ((bus.cnt_if | bus.cnt_d | bus.cnt_ld | bus.cnt_stall) !== 32'h0) $display("FAIL mid_cnt: got %h %h %h %h exp 0", bus.cnt_if, bus.cnt_d, bus.cnt_ld, bus.cnt_stall); else pass_cnt++;
`endif
    rst = 1'b1;
    @(negedge clk); #1;
    total_cnt++; if (bus.d_rvalid !== 1'b0 || bus.ram_en !== 1'b0 || bus.locked !== 1'b0) $display("FAIL mid_after: got rv=%b en=%b locked=%b exp 0 0 0", bus.d_rvalid, bus.ram_en, bus.locked); else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) $display("FAIL mid_late: got rv=%b data=%h exp 0 0", bus.d_rvalid, bus.d_rdata); else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0;
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_ld_unlocked();
    test_fetch();
    test_partial_write();
    test_starvation();
    test_lock();
    test_reset_midread();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
